// File: rtl/mul_div_seq_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide sequencer.
package mul_div_seq_pkg;

    localparam int unsigned XLEN_W = 32;

    typedef logic [XLEN_W-1:0] word_t;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    typedef logic [1:0] mdu_state_t;

    localparam mdu_state_t ST_IDLE = 2'd0;
    localparam mdu_state_t ST_CALC = 2'd1;
    localparam mdu_state_t ST_FIX  = 2'd2;
    localparam mdu_state_t ST_DONE = 2'd3;

    // rs1 is treated as signed (MUL low half is sign-agnostic, so signed is fine)
    function automatic logic is_signed_a(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // rs2 is treated as signed
    function automatic logic is_signed_b(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic is_mul_op(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_MULHSU) || (op == MDU_MULHU);
    endfunction

    function automatic logic is_rem_op(input mdu_op_t op);
        return (op == MDU_REM) || (op == MDU_REMU);
    endfunction

endpackage

// File: rtl/mul_div_seq_sign_fix.sv
// FIX stage: restore the result sign and pick the product half, quotient or remainder.
module mul_div_seq_sign_fix
    import mul_div_seq_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_W
) (
    input  mdu_op_t             op,
    input  logic                sign_a,
    input  logic                sign_b,
    input  logic [2*XLEN-1:0]   prod,
    input  logic [XLEN-1:0]     rem,
    output logic [XLEN-1:0]     res_c
);

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    // Unsigned ops never set the sign flags, so one negate rule covers all variants
    always_comb begin
        prod_s = (sign_a ^ sign_b) ? (~prod + (2*XLEN)'(1)) : prod;
        quo_s  = (sign_a ^ sign_b) ? (~prod[XLEN-1:0] + XLEN'(1)) : prod[XLEN-1:0];
        rem_s  = sign_a ? (~rem + XLEN'(1)) : rem;
        res_c  = rem_s;
        case (op)
            MDU_MUL:                          res_c = prod_s[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  res_c = prod_s[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                res_c = quo_s;
            default:                          res_c = rem_s;
        endcase
    end

endmodule

// File: rtl/mul_div_seq.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle, start/busy/done handshake.
module mul_div_seq
    import mul_div_seq_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_W,
    parameter bit          FAST_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t state;
    mdu_state_t state_next;

    mdu_op_t    op_in;
    mdu_op_t    op_q;
    logic       sign_a_q;
    logic       sign_b_q;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   rem;

    logic              accept;
    logic              special;
    logic [XLEN-1:0]   special_val;
    logic              sign_a_in;
    logic              sign_b_in;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_sub;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem_next;
    logic [XLEN-1:0]   div_quo_next;

    logic [XLEN-1:0]   fix_res_c;

    assign op_in  = mdu_op_t'(op);
    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    // Decide at accept time whether the op finishes without iterating
    always_comb begin
        special     = 1'b0;
        special_val = '0;
        if (is_mul_op(op_in)) begin
            if (FAST_ZERO && ((a == '0) || (b == '0))) begin
                special = 1'b1;
            end
        end else if (b == '0) begin
            special     = 1'b1;
            special_val = is_rem_op(op_in) ? a : '1;
        end else if ((a == MIN_INT) && (b == '1) && (op_in == MDU_DIV)) begin
            special     = 1'b1;
            special_val = MIN_INT;
        end else if ((a == MIN_INT) && (b == '1) && (op_in == MDU_REM)) begin
            special     = 1'b1;
        end
    end

    // Operand magnitudes per the signedness of the requested op
    always_comb begin
        sign_a_in = is_signed_a(op_in) & a[XLEN-1];
        sign_b_in = is_signed_b(op_in) & b[XLEN-1];
        mag_a     = sign_a_in ? (~a + XLEN'(1)) : a;
        mag_b     = sign_b_in ? (~b + XLEN'(1)) : b;
    end

    // One iteration of shift-add multiply and of restoring division
    always_comb begin
        mul_sum = {1'b0, prod[2*XLEN-1:XLEN]};
        if (prod[0]) begin
            mul_sum = mul_sum + {1'b0, mcand};
        end
        mul_next = {mul_sum, prod[XLEN-1:1]};

        div_shift = {rem, prod[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mcand});
        div_sub   = div_shift[XLEN-1:0] - mcand;
        if (div_ge) begin
            div_rem_next = div_sub;
            div_quo_next = {prod[XLEN-2:0], 1'b1};
        end else begin
            div_rem_next = div_shift[XLEN-1:0];
            div_quo_next = {prod[XLEN-2:0], 1'b0};
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == '0) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (accept) begin
                    state_next = special ? ST_DONE : ST_CALC;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_CALC) || (state_next == ST_FIX);
            done  <= (state_next == ST_DONE);
        end
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= MDU_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt      <= '0;
            mcand    <= '0;
            prod     <= '0;
            rem      <= '0;
            res      <= '0;
        end else if (accept) begin
            op_q     <= op_in;
            sign_a_q <= sign_a_in;
            sign_b_q <= sign_b_in;
            cnt      <= CNT_W'(XLEN - 1);
            rem      <= '0;
            if (is_mul_op(op_in)) begin
                mcand <= mag_a;
                prod  <= {{XLEN{1'b0}}, mag_b};
            end else begin
                mcand <= mag_b;
                prod  <= {{XLEN{1'b0}}, mag_a};
            end
            if (special) begin
                res <= special_val;
            end
        end else if (state == ST_CALC) begin
            cnt <= cnt - CNT_W'(1);
            if (is_mul_op(op_q)) begin
                prod <= mul_next;
            end else begin
                prod <= {prod[2*XLEN-1:XLEN], div_quo_next};
                rem  <= div_rem_next;
            end
        end else if (state == ST_FIX) begin
            res <= fix_res_c;
        end
    end

    mul_div_seq_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .op     (op_q),
        .sign_a (sign_a_q),
        .sign_b (sign_b_q),
        .prod   (prod),
        .rem    (rem),
        .res_c  (fix_res_c)
    );

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed self-checking bench for mul_div_seq.
module tb_mul_div_seq;
    import mul_div_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int pass_cnt = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    mul_div_seq #(
        .XLEN      (32),
        .FAST_ZERO (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    // Issue one op from IDLE; lat=1 is the cycle right after the accepting edge
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int busy_cyc, output logic [31:0] r);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        r = res;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        check_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        check_cnt++; if (res !== 32'd0) $display("FAIL reset_res: got %h expected 0", res); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mul;
        int lat; int bc; logic [31:0] r;
        run_op(MDU_MUL, 32'd7, 32'd6, lat, bc, r);
        check_cnt++; if (r !== 32'd42) $display("FAIL mul_res: got %h expected %h", r, 32'd42); else pass_cnt++;
        check_cnt++; if (lat != 34) $display("FAIL mul_latency: got %0d expected 34", lat); else pass_cnt++;
        check_cnt++; if (bc != 33) $display("FAIL mul_busy_cycles: got %0d expected 33", bc); else pass_cnt++;
    endtask

    task automatic test_mul_high;
        int lat; int bc; logic [31:0] r;
        run_op(MDU_MULH, 32'h8000_0000, 32'h8000_0000, lat, bc, r);
        check_cnt++; if (r !== 32'h4000_0000) $display("FAIL mulh_res: got %h expected 40000000", r); else pass_cnt++;
        run_op(MDU_MULHU, 32'h8000_0000, 32'h8000_0000, lat, bc, r);
        check_cnt++; if (r !== 32'h4000_0000) $display("FAIL mulhu_res: got %h expected 40000000", r); else pass_cnt++;
        run_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'd2, lat, bc, r);
        check_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL mulhsu_res: got %h expected ffffffff", r); else pass_cnt++;
        run_op(MDU_MULH, 32'hFFFF_FFFD, 32'd5, lat, bc, r);
        check_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL mulh_neg_res: got %h expected ffffffff", r); else pass_cnt++;
        run_op(MDU_MUL, 32'hFFFF_FFFD, 32'd5, lat, bc, r);
        check_cnt++; if (r !== 32'hFFFF_FFF1) $display("FAIL mul_neg_res: got %h expected fffffff1", r); else pass_cnt++;
    endtask

    task automatic test_div;
        int lat; int bc; logic [31:0] r;
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc, r);
        check_cnt++; if (r !== 32'hFFFF_FFFD) $display("FAIL div_res: got %h expected fffffffd", r); else pass_cnt++;
        check_cnt++; if (lat != 34) $display("FAIL div_latency: got %0d expected 34", lat); else pass_cnt++;
        run_op(MDU_REM, 32'hFFFF_FFF9, 32'd2, lat, bc, r);
        check_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL rem_res: got %h expected ffffffff", r); else pass_cnt++;
        run_op(MDU_DIVU, 32'd100, 32'd7, lat, bc, r);
        check_cnt++; if (r !== 32'd14) $display("FAIL divu_res: got %h expected %h", r, 32'd14); else pass_cnt++;
        run_op(MDU_REMU, 32'd100, 32'd7, lat, bc, r);
        check_cnt++; if (r !== 32'd2) $display("FAIL remu_res: got %h expected %h", r, 32'd2); else pass_cnt++;
        run_op(MDU_DIV, 32'd20, 32'hFFFF_FFFA, lat, bc, r);
        check_cnt++; if (r !== 32'hFFFF_FFFD) $display("FAIL div_negb_res: got %h expected fffffffd", r); else pass_cnt++;
    endtask

    task automatic test_special;
        int lat; int bc; logic [31:0] r;
        run_op(MDU_DIVU, 32'd5, 32'd0, lat, bc, r);
        check_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL divu_by0_res: got %h expected ffffffff", r); else pass_cnt++;
        check_cnt++; if (lat != 1) $display("FAIL divu_by0_latency: got %0d expected 1", lat); else pass_cnt++;
        run_op(MDU_REM, 32'd5, 32'd0, lat, bc, r);
        check_cnt++; if (r !== 32'd5) $display("FAIL rem_by0_res: got %h expected 5", r); else pass_cnt++;
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, r);
        check_cnt++; if (r !== 32'h8000_0000) $display("FAIL div_ovf_res: got %h expected 80000000", r); else pass_cnt++;
        check_cnt++; if (lat != 1) $display("FAIL div_ovf_latency: got %0d expected 1", lat); else pass_cnt++;
        run_op(MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, r);
        check_cnt++; if (r !== 32'd0) $display("FAIL rem_ovf_res: got %h expected 0", r); else pass_cnt++;
        run_op(MDU_MULHU, 32'd0, 32'h1234_5678, lat, bc, r);
        check_cnt++; if (r !== 32'd0) $display("FAIL mul_zero_res: got %h expected 0", r); else pass_cnt++;
        check_cnt++; if (lat != 1) $display("FAIL mul_zero_latency: got %0d expected 1", lat); else pass_cnt++;
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        start = 1'b1; op = MDU_MUL; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            if (busy === 1'b1 && (lat % 5) == 2) begin
                start = 1'b1; op = MDU_DIVU; a = 32'd99; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check_cnt++; if (lat != 34) $display("FAIL ignore_latency: got %0d expected 34", lat); else pass_cnt++;
        check_cnt++; if (res !== 32'd15) $display("FAIL ignore_res: got %h expected %h", res, 32'd15); else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        check_cnt++; if (done !== 1'b0) $display("FAIL ignore_no_extra_done: got %b expected 0", done); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL ignore_idle_busy: got %b expected 0", busy); else pass_cnt++;
        check_cnt++; if (res !== 32'd15) $display("FAIL ignore_res_held: got %h expected %h", res, 32'd15); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_cnt++; if (res !== 32'd14) $display("FAIL b2b_first_res: got %h expected %h", res, 32'd14); else pass_cnt++;
        @(negedge clk);
        start = 1'b1; op = MDU_REMU; a = 32'd100; b = 32'd7;
        check_cnt++; if (done !== 1'b1) $display("FAIL b2b_done_in_accept_cycle: got %b expected 1", done); else pass_cnt++;
        @(posedge clk); #1;
        start = 1'b0;
        check_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy_after_accept: got %b expected 1", busy); else pass_cnt++;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_cnt++; if (lat != 34) $display("FAIL b2b_second_latency: got %0d expected 34", lat); else pass_cnt++;
        check_cnt++; if (res !== 32'd2) $display("FAIL b2b_second_res: got %h expected %h", res, 32'd2); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat; int bc; logic [31:0] r; logic seen_done;
        @(negedge clk);
        start = 1'b1; op = MDU_MUL; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_cnt++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else pass_cnt++;
        check_cnt++; if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done); else pass_cnt++;
        check_cnt++; if (res !== 32'd0) $display("FAIL midreset_res: got %h expected 0", res); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        check_cnt++; if (seen_done !== 1'b0) $display("FAIL midreset_no_done: got %b expected 0", seen_done); else pass_cnt++;
        run_op(MDU_DIVU, 32'd9, 32'd3, lat, bc, r);
        check_cnt++; if (r !== 32'd3) $display("FAIL midreset_next_res: got %h expected 3", r); else pass_cnt++;
        check_cnt++; if (lat != 34) $display("FAIL midreset_next_latency: got %0d expected 34", lat); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
